// File: rtl/chipper_pkg.sv
// rtl/chipper_pkg.sv - shared flit field definitions for the chipper input stage
package chipper_pkg;

  localparam int FLIT_W   = 10;
  localparam int INJ_W    = 9;
  localparam int GOLD_BIT = 9;
  localparam int DEST_HI  = 8;
  localparam int DEST_LO  = 6;
  localparam int PAY_HI   = 5;
  localparam int PAY_LO   = 0;

  localparam logic [2:0]        DEST_BUBBLE = 3'b111;
  localparam logic [FLIT_W-1:0] BUBBLE      = 10'h1C0;

  function automatic logic [2:0] flit_dest(input logic [FLIT_W-1:0] f);
    return f[DEST_HI:DEST_LO];
  endfunction

  function automatic logic is_bubble(input logic [FLIT_W-1:0] f);
    return f[DEST_HI:DEST_LO] == DEST_BUBBLE;
  endfunction

endpackage

// File: rtl/chipper_inject_eject_if.sv
// rtl/chipper_inject_eject_if.sv - link, injection and ejection signals of the input stage
interface chipper_inject_eject_if;
  import chipper_pkg::*;

  logic [FLIT_W-1:0] inp1;
  logic [FLIT_W-1:0] inp2;
  logic [INJ_W-1:0]  inj_data;
  logic              inj_valid;
  logic              inj_ready;
  logic [FLIT_W-1:0] out1;
  logic [FLIT_W-1:0] out2;
  logic [FLIT_W-1:0] ej_data;
  logic              ej_valid;
  logic              inj_starve;

  modport master (
    output inp1, inp2, inj_data, inj_valid,
    input  inj_ready, out1, out2, ej_data, ej_valid, inj_starve
  );

  modport slave (
    input  inp1, inp2, inj_data, inj_valid,
    output inj_ready, out1, out2, ej_data, ej_valid, inj_starve
  );

endinterface

// File: rtl/chipper_inject_eject_fifo.sv
// rtl/chipper_inject_eject_fifo.sv - local injection queue with registered occupancy
module flit_fifo
  import chipper_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = INJ_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [W-1:0]       data_i,
  input  logic               pop_i,
  output logic [W-1:0]       head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt the pointers.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/chipper_inject_eject.sv
// rtl/chipper_inject_eject.sv - eject one local flit, inject one queued flit, register both slots
module chipper_inject_eject
  import chipper_pkg::*;
#(
  parameter logic [2:0] LOCAL_ID     = 3'b110,
  parameter int         DEPTH        = 4,
  parameter int         STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  chipper_inject_eject_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [FLIT_W-1:0] out1_q, out1_d, out2_q, out2_d, ej_data_q, ej_data_d;
  logic              ej_valid_q, ej_valid_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [INJ_W-1:0]  head;
  logic              full, empty, push, pop;
  logic              cand1, cand2, take2;
  logic [$clog2(DEPTH):0] fifo_count;

  // Ready is low while reset is held so nothing is accepted in the reset cycle.
  assign bus.inj_ready = !full && !rst;
  // Bubble-addressed local flits are accepted but dropped.
  assign push = bus.inj_valid && bus.inj_ready && (bus.inj_data[8:6] != DEST_BUBBLE);

  flit_fifo #(.DEPTH(DEPTH), .W(INJ_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (bus.inj_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  // Slot logic: eject first, then fill the first bubble from the queue head.
  always_comb begin
    out1_d     = bus.inp1;
    out2_d     = bus.inp2;
    ej_data_d  = '0;
    ej_valid_d = 1'b0;
    pop        = 1'b0;
    cand1      = flit_dest(bus.inp1) == LOCAL_ID;
    cand2      = flit_dest(bus.inp2) == LOCAL_ID;
    // Slot 2 only wins a tie when it alone carries the golden bit.
    take2      = cand2 && (!cand1 || (bus.inp2[GOLD_BIT] && !bus.inp1[GOLD_BIT]));
    if (take2) begin
      ej_data_d  = bus.inp2;
      ej_valid_d = 1'b1;
      out2_d     = BUBBLE;
    end else if (cand1) begin
      ej_data_d  = bus.inp1;
      ej_valid_d = 1'b1;
      out1_d     = BUBBLE;
    end
    // empty reflects the registered count, so a flit pushed this cycle waits.
    if (!empty) begin
      if (is_bubble(out1_d)) begin
        out1_d = {1'b0, head};
        pop    = 1'b1;
      end else if (is_bubble(out2_d)) begin
        out2_d = {1'b0, head};
        pop    = 1'b1;
      end
    end
  end

  // Starvation count: runs while work is queued but blocked, saturating.
  always_comb begin
    starve_d = starve_q;
    if (empty || pop)                    starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1_q     <= BUBBLE;
      out2_q     <= BUBBLE;
      ej_data_q  <= '0;
      ej_valid_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      ej_data_q  <= ej_data_d;
      ej_valid_q <= ej_valid_d;
      starve_q   <= starve_d;
    end
  end

  assign bus.out1       = out1_q;
  assign bus.out2       = out2_q;
  assign bus.ej_data    = ej_data_q;
  assign bus.ej_valid   = ej_valid_q;
  assign bus.inj_starve = starve_q == SW'(STARVE_LIMIT);

endmodule

// File: tb/tb_chipper_inject_eject.sv
// tb/tb_chipper_inject_eject.sv - scoreboard bench for chipper_inject_eject
module tb_chipper_inject_eject;
  import chipper_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 15;

  typedef struct packed {
    logic [9:0] o1;
    logic [9:0] o2;
    logic [9:0] ej;
    logic       ejv;
    logic       rdy;
    logic       stv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  exp_t       sb[$];
  logic [8:0] mq[$];
  int         mstarve = 0;

  chipper_inject_eject_if bus();

  chipper_inject_eject #(.LOCAL_ID(3'b110), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Drive one cycle, predict the registered result, then compare after the edge.
  task automatic step(input logic r, input logic [9:0] a, input logic [9:0] b,
                      input logic [8:0] d, input logic v);
    exp_t       e;
    exp_t       got;
    logic [9:0] s1, s2;
    logic [8:0] h;
    bit         was_empty, popped, ready_now;
    rst = r;
    bus.inp1 = a;
    bus.inp2 = b;
    bus.inj_data = d;
    bus.inj_valid = v;
    ready_now = !r && (mq.size() < DEPTH);
    e = '0;
    if (r) begin
      mq.delete();
      mstarve = 0;
      e.o1 = 10'h1C0;
      e.o2 = 10'h1C0;
    end else begin
      s1 = a;
      s2 = b;
      if (a[8:6] == 3'b110 && !(b[8:6] == 3'b110 && b[9] && !a[9])) begin
        e.ej = a; e.ejv = 1'b1; s1 = 10'h1C0;
      end else if (b[8:6] == 3'b110) begin
        e.ej = b; e.ejv = 1'b1; s2 = 10'h1C0;
      end
      was_empty = mq.size() == 0;
      popped = 0;
      if (!was_empty && s1[8:6] == 3'b111) begin
        h = mq.pop_front(); s1 = {1'b0, h}; popped = 1;
      end else if (!was_empty && s2[8:6] == 3'b111) begin
        h = mq.pop_front(); s2 = {1'b0, h}; popped = 1;
      end
      if (v && ready_now && d[8:6] != 3'b111) mq.push_back(d);
      if (was_empty || popped) mstarve = 0;
      else if (mstarve < LIMIT) mstarve++;
      e.o1 = s1;
      e.o2 = s2;
      e.rdy = mq.size() < DEPTH;
      e.stv = mstarve == LIMIT;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = {bus.out1, bus.out2, bus.ej_data, bus.ej_valid, bus.inj_ready, bus.inj_starve};
    e = sb.pop_front();
    check("sb_out1", 32'(got.o1), 32'(e.o1));
    check("sb_out2", 32'(got.o2), 32'(e.o2));
    check("sb_ej_valid", 32'(got.ejv), 32'(e.ejv));
    if (e.ejv) check("sb_ej_data", 32'(got.ej), 32'(e.ej));
    check("sb_inj_ready", 32'(got.rdy), 32'(e.rdy));
    check("sb_inj_starve", 32'(got.stv), 32'(e.stv));
  endtask

  function automatic logic [9:0] rand_flit();
    int         k;
    logic [2:0] dst;
    k = $urandom_range(0, 7);
    if (k < 2)      dst = 3'b110;
    else if (k < 4) dst = 3'b111;
    else            dst = 3'($urandom_range(0, 5));
    return {1'($urandom_range(0, 1)), dst, 6'($urandom_range(0, 63))};
  endfunction

  initial begin
    // Reset: outputs at reset values, ready held low while rst is high.
    step(1, 10'h1C0, 10'h1C0, 9'h000, 0);
    step(1, 10'h1C0, 10'h1C0, 9'h000, 0);
    check("rst_out1", 32'(bus.out1), 32'h1C0);
    check("rst_out2", 32'(bus.out2), 32'h1C0);
    check("rst_ej_data", 32'(bus.ej_data), 32'h000);
    check("rst_ready_low", 32'(bus.inj_ready), 32'h0);
    step(0, 10'h1C0, 10'h1C0, 9'h000, 0);
    check("rst_ready_high", 32'(bus.inj_ready), 32'h1);

    // Pass-through with empty queue.
    step(0, 10'h2C5, 10'h040, 9'h000, 0);
    check("pt_out1", 32'(bus.out1), 32'h2C5);
    check("pt_out2", 32'(bus.out2), 32'h040);
    check("pt_ej_valid", 32'(bus.ej_valid), 32'h0);

    // Queue one flit, then eject slot 1 and inject into the freed slot.
    step(0, 10'h2C5, 10'h040, 9'h045, 1);
    step(0, 10'h1A3, 10'h0C1, 9'h000, 0);
    check("ei_ej_data", 32'(bus.ej_data), 32'h1A3);
    check("ei_ej_valid", 32'(bus.ej_valid), 32'h1);
    check("ei_out1", 32'(bus.out1), 32'h045);
    check("ei_out2", 32'(bus.out2), 32'h0C1);

    // Two local flits: golden slot 2 wins, queue empty so bubble stays.
    step(0, 10'h181, 10'h382, 9'h000, 0);
    check("gold_ej_data", 32'(bus.ej_data), 32'h382);
    check("gold_out1", 32'(bus.out1), 32'h181);
    check("gold_out2", 32'(bus.out2), 32'h1C0);

    // Fill the queue under blocking traffic, offer one more while full.
    for (int k = 0; k < 4; k++) step(0, 10'h2C5, 10'h040, 9'(9'h0A0 + k), 1);
    check("full_ready", 32'(bus.inj_ready), 32'h0);
    step(0, 10'h2C5, 10'h040, 9'h0FF, 1);
    step(0, 10'h2C5, 10'h1C0, 9'h000, 0);
    check("full_pop_out2", 32'(bus.out2), 32'h0A0);
    check("full_ready_back", 32'(bus.inj_ready), 32'h1);

    // Starvation: one queued flit blocked for LIMIT cycles.
    step(1, 10'h1C0, 10'h1C0, 9'h000, 0);
    step(0, 10'h2C5, 10'h040, 9'h055, 1);
    for (int i = 1; i <= LIMIT; i++) begin
      step(0, 10'h2C5, 10'h040, 9'h000, 0);
      check("starve_ramp", 32'(bus.inj_starve), 32'(i == LIMIT));
    end
    step(0, 10'h1C0, 10'h2C5, 9'h000, 0);
    check("starve_inject", 32'(bus.out1), 32'h055);
    check("starve_clear", 32'(bus.inj_starve), 32'h0);

    // Reset mid-operation discards queued flits.
    for (int k = 0; k < 3; k++) step(0, 10'h2C5, 10'h040, 9'(9'h011 + k), 1);
    step(1, 10'h2C5, 10'h040, 9'h000, 0);
    check("mid_rst_out1", 32'(bus.out1), 32'h1C0);
    check("mid_rst_ejv", 32'(bus.ej_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(0, 10'h1C0, 10'h1C0, 9'h000, 0);
      check("mid_rst_noinj1", 32'(bus.out1), 32'h1C0);
      check("mid_rst_noinj2", 32'(bus.out2), 32'h1C0);
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0), rand_flit(), rand_flit(),
           {($urandom_range(0, 5) == 0) ? 3'b111 : 3'($urandom_range(0, 6)), 6'($urandom_range(0, 63))},
           1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
